pixel_pack_1to8: RTL and testbench

//  Serial-to-parallel video packer feeding the 8-port result-image writer stage.

---
 rtl/pixel_pack_1to8.sv | 136 +++++++++++++
 tb/tb_pixel_pack_1to8.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pack_1to8.sv
// Packs a 1-pixel/clock RGB stream into 8-pixel beats and pads a trailing partial group at de fall.
// Latency 1 cycle from the 8th (or flushing) pixel to de_out; no backpressure, downstream must take every beat.
module pixel_pack_1to8 #(
    parameter logic [7:0] PAD_VAL = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vs_in,
    input  logic       hs_in,
    input  logic       de_in,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic       vs_out,
    output logic       hs_out,
    output logic       de_out,
    output logic [7:0] r_out_01,
    output logic [7:0] r_out_02,
    output logic [7:0] r_out_03,
    output logic [7:0] r_out_04,
    output logic [7:0] r_out_05,
    output logic [7:0] r_out_06,
    output logic [7:0] r_out_07,
    output logic [7:0] r_out_08,
    output logic [7:0] g_out_01,
    output logic [7:0] g_out_02,
    output logic [7:0] g_out_03,
    output logic [7:0] g_out_04,
    output logic [7:0] g_out_05,
    output logic [7:0] g_out_06,
    output logic [7:0] g_out_07,
    output logic [7:0] g_out_08,
    output logic [7:0] b_out_01,
    output logic [7:0] b_out_02,
    output logic [7:0] b_out_03,
    output logic [7:0] b_out_04,
    output logic [7:0] b_out_05,
    output logic [7:0] b_out_06,
    output logic [7:0] b_out_07,
    output logic [7:0] b_out_08,
    output logic [3:0] valid_cnt,
    output logic       partial
);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    logic [2:0] cnt;
    pix_t       pix_buf [0:7];
    pix_t       beat    [0:7];
    pix_t       cur_pix;
    pix_t       pad_pix;
    logic       full_grp;
    logic       flush_grp;

    assign cur_pix   = {r_in, g_in, b_in};
    assign pad_pix   = {PAD_VAL, PAD_VAL, PAD_VAL};
    assign full_grp  = de_in && (cnt == 3'd7);
    assign flush_grp = !de_in && (cnt != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 3'd0;
            vs_out    <= 1'b0;
            hs_out    <= 1'b0;
            de_out    <= 1'b0;
            valid_cnt <= 4'd0;
            partial   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                pix_buf[i] <= '0;
                beat[i]    <= '0;
            end
        end else begin
            vs_out  <= vs_in;
            hs_out  <= hs_in;
            de_out  <= full_grp || flush_grp;
            partial <= flush_grp;

            if (full_grp)
                valid_cnt <= 4'd8;
            else if (flush_grp)
                valid_cnt <= {1'b0, cnt};
            else
                valid_cnt <= 4'd0;

            // cnt wraps 7->0 naturally on a full group
            if (de_in) begin
                pix_buf[cnt] <= cur_pix;
                cnt          <= cnt + 3'd1;
            end else if (flush_grp) begin
                cnt <= 3'd0;
            end

            // Last slot of a full group comes straight from the input, not the buffer
            if (full_grp) begin
                for (int i = 0; i < 7; i++)
                    beat[i] <= pix_buf[i];
                beat[7] <= cur_pix;
            end else if (flush_grp) begin
                for (int i = 0; i < 8; i++)
                    beat[i] <= (3'(i) < cnt) ? pix_buf[i] : pad_pix;
            end
        end
    end

    assign r_out_01 = beat[0].r;
    assign r_out_02 = beat[1].r;
    assign r_out_03 = beat[2].r;
    assign r_out_04 = beat[3].r;
    assign r_out_05 = beat[4].r;
    assign r_out_06 = beat[5].r;
    assign r_out_07 = beat[6].r;
    assign r_out_08 = beat[7].r;

    assign g_out_01 = beat[0].g;
    assign g_out_02 = beat[1].g;
    assign g_out_03 = beat[2].g;
    assign g_out_04 = beat[3].g;
    assign g_out_05 = beat[4].g;
    assign g_out_06 = beat[5].g;
    assign g_out_07 = beat[6].g;
    assign g_out_08 = beat[7].g;

    assign b_out_01 = beat[0].b;
    assign b_out_02 = beat[1].b;
    assign b_out_03 = beat[2].b;
    assign b_out_04 = beat[3].b;
    assign b_out_05 = beat[4].b;
    assign b_out_06 = beat[5].b;
    assign b_out_07 = beat[6].b;
    assign b_out_08 = beat[7].b;

endmodule

// File: tb/tb_pixel_pack_1to8.sv
// Directed bench for pixel_pack_1to8: reset, single group, full line, flush, reset mid-group, sync delay.
module tb_pixel_pack_1to8;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs_in, hs_in, de_in;
    logic [7:0] r_in, g_in, b_in;
    logic       vs_out, hs_out, de_out, partial;
    logic [3:0] valid_cnt;
    logic [7:0] r_out_01, r_out_02, r_out_03, r_out_04, r_out_05, r_out_06, r_out_07, r_out_08;
    logic [7:0] g_out_01, g_out_02, g_out_03, g_out_04, g_out_05, g_out_06, g_out_07, g_out_08;
    logic [7:0] b_out_01, b_out_02, b_out_03, b_out_04, b_out_05, b_out_06, b_out_07, b_out_08;

    logic [7:0] r_o [8];
    logic [7:0] g_o [8];
    logic [7:0] b_o [8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pixel_pack_1to8 #(.PAD_VAL(8'd0)) dut (
        .clk(clk), .rst(rst),
        .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
        .r_out_01(r_out_01), .r_out_02(r_out_02), .r_out_03(r_out_03), .r_out_04(r_out_04),
        .r_out_05(r_out_05), .r_out_06(r_out_06), .r_out_07(r_out_07), .r_out_08(r_out_08),
        .g_out_01(g_out_01), .g_out_02(g_out_02), .g_out_03(g_out_03), .g_out_04(g_out_04),
        .g_out_05(g_out_05), .g_out_06(g_out_06), .g_out_07(g_out_07), .g_out_08(g_out_08),
        .b_out_01(b_out_01), .b_out_02(b_out_02), .b_out_03(b_out_03), .b_out_04(b_out_04),
        .b_out_05(b_out_05), .b_out_06(b_out_06), .b_out_07(b_out_07), .b_out_08(b_out_08),
        .valid_cnt(valid_cnt), .partial(partial)
    );

    assign r_o[0] = r_out_01; assign r_o[1] = r_out_02; assign r_o[2] = r_out_03; assign r_o[3] = r_out_04;
    assign r_o[4] = r_out_05; assign r_o[5] = r_out_06; assign r_o[6] = r_out_07; assign r_o[7] = r_out_08;
    assign g_o[0] = g_out_01; assign g_o[1] = g_out_02; assign g_o[2] = g_out_03; assign g_o[3] = g_out_04;
    assign g_o[4] = g_out_05; assign g_o[5] = g_out_06; assign g_o[6] = g_out_07; assign g_o[7] = g_out_08;
    assign b_o[0] = b_out_01; assign b_o[1] = b_out_02; assign b_o[2] = b_out_03; assign b_o[3] = b_out_04;
    assign b_o[4] = b_out_05; assign b_o[5] = b_out_06; assign b_o[6] = b_out_07; assign b_o[7] = b_out_08;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        de_in = 1'b1;
        r_in  = r;
        g_in  = g;
        b_in  = b;
        step();
    endtask

    task automatic idle();
        de_in = 1'b0;
        r_in  = 8'h00;
        g_in  = 8'h00;
        b_in  = 8'h00;
        step();
    endtask

    initial begin
        int beats, last, gaps, parts;
        logic pv, ph;

        // T1: reset held while the stream is active
        rst = 1'b1; vs_in = 1'b1; hs_in = 1'b1; de_in = 1'b1;
        r_in = 8'h5A; g_in = 8'hA5; b_in = 8'h3C;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_de_out", 32'(de_out), 32'd0);
        end
        chk("rst_vs_out", 32'(vs_out), 32'd0);
        chk("rst_hs_out", 32'(hs_out), 32'd0);
        chk("rst_valid_cnt", 32'(valid_cnt), 32'd0);
        chk("rst_partial", 32'(partial), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rst_r%0d", i + 1), 32'(r_o[i]), 32'd0);
            chk($sformatf("rst_g%0d", i + 1), 32'(g_o[i]), 32'd0);
            chk($sformatf("rst_b%0d", i + 1), 32'(b_o[i]), 32'd0);
        end
        rst = 1'b0; vs_in = 1'b0; hs_in = 1'b0;
        idle();
        chk("post_rst_de_out", 32'(de_out), 32'd0);

        // T2: one full group
        for (int k = 0; k < 8; k++) begin
            pix(8'(k + 1), 8'(16 + k), 8'hAA);
            if (k == 6) chk("t2_no_early_beat", 32'(de_out), 32'd0);
        end
        chk("t2_de_out", 32'(de_out), 32'd1);
        chk("t2_valid_cnt", 32'(valid_cnt), 32'd8);
        chk("t2_partial", 32'(partial), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_r%0d", i + 1), 32'(r_o[i]), 32'(i + 1));
            chk($sformatf("t2_g%0d", i + 1), 32'(g_o[i]), 32'(16 + i));
        end
        chk("t2_g8", 32'(g_out_08), 32'h17);
        chk("t2_b1", 32'(b_out_01), 32'hAA);
        idle();
        chk("t2_one_cycle", 32'(de_out), 32'd0);
        chk("t2_valid_clr", 32'(valid_cnt), 32'd0);
        chk("t2_hold_r1", 32'(r_out_01), 32'd1);
        chk("t2_hold_r8", 32'(r_out_08), 32'd8);

        // T3: 1920-pixel line
        beats = 0; last = -1; gaps = 0; parts = 0;
        for (int i = 0; i < 1920; i++) begin
            pix(8'(i), 8'h00, 8'h00);
            if (de_out) begin
                if (last >= 0 && (i - last) != 8) gaps++;
                last = i;
                beats++;
                if (partial) parts++;
            end
        end
        chk("t3_last_r1", 32'(r_out_01), 32'd120);
        chk("t3_last_r8", 32'(r_out_08), 32'd127);
        idle();
        if (de_out) beats++;
        chk("t3_beats", 32'(beats), 32'd240);
        chk("t3_gaps", 32'(gaps), 32'd0);
        chk("t3_partials", 32'(parts), 32'd0);

        // T4: 11-pixel run, trailing 3 pixels flushed with padding
        for (int k = 1; k <= 11; k++) begin
            pix(8'(k), 8'(k + 100), 8'h00);
            if (k == 8) begin
                chk("t4_b1_de_out", 32'(de_out), 32'd1);
                chk("t4_b1_valid", 32'(valid_cnt), 32'd8);
                chk("t4_b1_r1", 32'(r_out_01), 32'd1);
                chk("t4_b1_r8", 32'(r_out_08), 32'd8);
            end
        end
        chk("t4_no_beat_yet", 32'(de_out), 32'd0);
        idle();
        chk("t4_b2_de_out", 32'(de_out), 32'd1);
        chk("t4_b2_valid", 32'(valid_cnt), 32'd3);
        chk("t4_b2_partial", 32'(partial), 32'd1);
        chk("t4_b2_r1", 32'(r_out_01), 32'd9);
        chk("t4_b2_r2", 32'(r_out_02), 32'd10);
        chk("t4_b2_r3", 32'(r_out_03), 32'd11);
        chk("t4_b2_g3", 32'(g_out_03), 32'd111);
        for (int i = 3; i < 8; i++) begin
            chk($sformatf("t4_pad_r%0d", i + 1), 32'(r_o[i]), 32'd0);
            chk($sformatf("t4_pad_g%0d", i + 1), 32'(g_o[i]), 32'd0);
        end
        idle();
        chk("t4_after_de_out", 32'(de_out), 32'd0);
        chk("t4_after_valid", 32'(valid_cnt), 32'd0);
        chk("t4_after_partial", 32'(partial), 32'd0);

        // T5: reset after 5 pixels discards the partial group
        for (int k = 0; k < 5; k++) pix(8'(50 + k), 8'h00, 8'h00);
        rst = 1'b1; de_in = 1'b0;
        step();
        chk("t5_rst_de_out", 32'(de_out), 32'd0);
        rst = 1'b0;
        idle();
        chk("t5_no_flush", 32'(de_out), 32'd0);
        beats = 0;
        for (int k = 0; k < 8; k++) begin
            pix(8'(20 + k), 8'h00, 8'h00);
            if (de_out) beats++;
        end
        chk("t5_one_beat", 32'(beats), 32'd1);
        chk("t5_de_out", 32'(de_out), 32'd1);
        chk("t5_r1", 32'(r_out_01), 32'd20);
        chk("t5_r8", 32'(r_out_08), 32'd27);
        chk("t5_valid", 32'(valid_cnt), 32'd8);
        idle();

        // T6: random vs/hs toggling during a continuous de run must not disturb grouping
        beats = 0;
        for (int i = 0; i < 200; i++) begin
            pv = 1'($urandom);
            ph = 1'($urandom);
            vs_in = pv;
            hs_in = ph;
            pix(8'(i), 8'h00, 8'h00);
            chk($sformatf("t6_vs_%0d", i), 32'(vs_out), 32'(pv));
            chk($sformatf("t6_hs_%0d", i), 32'(hs_out), 32'(ph));
            if (de_out) beats++;
        end
        chk("t6_beats", 32'(beats), 32'd25);
        chk("t6_last_r8", 32'(r_out_08), 32'd199);
        vs_in = 1'b0; hs_in = 1'b0;
        idle();

        // Scaled two-frame run: 2 frames x 4 lines x 64 pixels with hs/vs blanking -> 64 beats
        beats = 0;
        for (int f = 0; f < 2; f++) begin
            for (int ln = 0; ln < 4; ln++) begin
                for (int p = 0; p < 64; p++) begin
                    pix(8'(p), 8'(ln), 8'(f));
                    if (de_out) beats++;
                end
                hs_in = 1'b1;
                for (int c = 0; c < 6; c++) begin
                    idle();
                    if (de_out) beats++;
                end
                hs_in = 1'b0;
            end
            vs_in = 1'b1;
            for (int c = 0; c < 10; c++) begin
                idle();
                if (de_out) beats++;
            end
            vs_in = 1'b0;
        end
        chk("frames_beats", 32'(beats), 32'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
